// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester byte-serial controller for a shared byte-wide synchronous RAM
module mem_arbiter #(
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_done,
   output logic [31:0]       if_inst,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [1:0]        mem_len,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic              mem_done,
   output logic [31:0]       mem_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_dout,
   input  logic [7:0]        ram_din
);

   typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

   state_t              r_state, w_state_nxt;
   logic [2:0]          r_cnt, w_cnt_nxt;
   logic [2:0]          r_n, w_n_nxt;
   logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
   logic [31:0]         r_wdata, w_wdata_nxt;
   logic [31:0]         r_data, w_data_nxt;
   logic                r_if_done, w_if_done_nxt;
   logic                r_mem_done, w_mem_done_nxt;
   logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr_nxt;
   logic                r_ram_we, w_ram_we_nxt;
   logic [7:0]          r_ram_dout, w_ram_dout_nxt;
   logic [31:0]         r_if_inst, w_if_inst_nxt;
   logic [31:0]         r_mem_rdata, w_mem_rdata_nxt;

   logic [2:0]          w_step;
   logic [1:0]          w_idx;
   logic [31:0]         w_cap;
   logic [2:0]          w_len_n;
   logic                w_unused;

   // Upper request address bits fall outside the RAM and are dropped.
   assign w_unused = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

   assign if_done   = r_if_done;
   assign if_inst   = r_if_inst;
   assign mem_done  = r_mem_done;
   assign mem_rdata = r_mem_rdata;
   assign ram_addr  = r_ram_addr;
   assign ram_we    = r_ram_we;
   assign ram_dout  = r_ram_dout;

   // Next-state and next-output logic; the byte returned by the RAM is merged into the word each cycle.
   always_comb begin
      w_step          = r_cnt + 3'd1;
      w_idx           = r_cnt[1:0] - 2'd1;
      w_cap           = r_data;
      w_cap[{w_idx, 3'b000} +: 8] = ram_din;
      case (mem_len)
         2'b00:   w_len_n = 3'd1;
         2'b01:   w_len_n = 3'd2;
         default: w_len_n = 3'd4;
      endcase

      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_n_nxt         = r_n;
      w_addr_nxt      = r_addr;
      w_wdata_nxt     = r_wdata;
      w_data_nxt      = r_data;
      w_if_done_nxt   = 1'b0;
      w_mem_done_nxt  = 1'b0;
      w_ram_addr_nxt  = r_ram_addr;
      w_ram_we_nxt    = 1'b0;
      w_ram_dout_nxt  = r_ram_dout;
      w_if_inst_nxt   = r_if_inst;
      w_mem_rdata_nxt = r_mem_rdata;

      case (r_state)
         IDLE: begin
            // A done cycle is never an accept cycle: the requester still holds req then.
            if (!r_if_done && !r_mem_done) begin
               if (mem_req) begin
                  w_state_nxt    = mem_we ? MEM_WR : MEM_RD;
                  w_cnt_nxt      = 3'd0;
                  w_n_nxt        = w_len_n;
                  w_addr_nxt     = mem_addr[ADDR_W-1:0];
                  w_wdata_nxt    = mem_wdata;
                  w_data_nxt     = 32'd0;
                  w_ram_addr_nxt = mem_addr[ADDR_W-1:0];
                  if (mem_we) begin
                     w_ram_we_nxt   = 1'b1;
                     w_ram_dout_nxt = mem_wdata[7:0];
                  end
               end else if (if_req && !flush) begin
                  w_state_nxt    = IF_RD;
                  w_cnt_nxt      = 3'd0;
                  w_n_nxt        = 3'd4;
                  w_addr_nxt     = if_addr[ADDR_W-1:0];
                  w_data_nxt     = 32'd0;
                  w_ram_addr_nxt = if_addr[ADDR_W-1:0];
               end
            end
         end
         IF_RD, MEM_RD: begin
            if (r_state == IF_RD && flush) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = 3'd0;
            end else begin
               w_cnt_nxt = w_step;
               if (r_cnt != 3'd0)
                  w_data_nxt = w_cap;
               if (w_step < r_n)
                  w_ram_addr_nxt = r_addr + ADDR_W'(w_step);
               if (r_cnt == r_n) begin
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = 3'd0;
                  if (r_state == IF_RD) begin
                     w_if_done_nxt = 1'b1;
                     w_if_inst_nxt = w_cap;
                  end else begin
                     w_mem_done_nxt  = 1'b1;
                     w_mem_rdata_nxt = w_cap;
                  end
               end
            end
         end
         MEM_WR: begin
            if (w_step < r_n) begin
               w_cnt_nxt      = w_step;
               w_ram_addr_nxt = r_addr + ADDR_W'(w_step);
               w_ram_we_nxt   = 1'b1;
               w_ram_dout_nxt = r_wdata[{w_step[1:0], 3'b000} +: 8];
            end else begin
               w_state_nxt    = IDLE;
               w_cnt_nxt      = 3'd0;
               w_mem_done_nxt = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and registered outputs; reset abandons any access immediately.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_cnt       <= 3'd0;
         r_n         <= 3'd0;
         r_addr      <= '0;
         r_wdata     <= 32'd0;
         r_data      <= 32'd0;
         r_if_done   <= 1'b0;
         r_mem_done  <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_we    <= 1'b0;
         r_ram_dout  <= 8'd0;
         r_if_inst   <= 32'd0;
         r_mem_rdata <= 32'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_n         <= w_n_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_data      <= w_data_nxt;
         r_if_done   <= w_if_done_nxt;
         r_mem_done  <= w_mem_done_nxt;
         r_ram_addr  <= w_ram_addr_nxt;
         r_ram_we    <= w_ram_we_nxt;
         r_ram_dout  <= w_ram_dout_nxt;
         r_if_inst   <= w_if_inst_nxt;
         r_mem_rdata <= w_mem_rdata_nxt;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a byte RAM model
module tb_mem_arbiter;
   localparam int ADDR_W = 17;

   logic              clk = 1'b0;
   logic              rst, flush, if_req, mem_req, mem_we;
   logic [31:0]       if_addr, mem_addr, mem_wdata;
   logic [1:0]        mem_len;
   logic              if_done, mem_done, ram_we;
   logic [31:0]       if_inst, mem_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_dout, ram_din;

   logic [7:0]        ram [0:(1<<ADDR_W)-1];
   logic              pk_en = 1'b0;
   logic [ADDR_W-1:0] pk_a = '0;
   logic [7:0]        pk_d = 8'd0;

   int n_checks = 0, n_fail = 0;
   int n_if_done = 0, n_mem_done = 0, n_both = 0, cyc = 0;
   int last_we_cyc = 0, last_mem_done_cyc = 0;
   logic [ADDR_W-1:0] we_addr_q[$];
   logic [7:0]        we_data_q[$];
   logic [31:0]       if_exp_q[$], mem_exp_q[$];
   logic [31:0]       exp;
   int                lat, base;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout), .ram_din(ram_din)
   );

   // Synchronous RAM model, one-cycle read latency; pk_* preloads bytes while the DUT is idle.
   always @(posedge clk) begin
      if (pk_en) ram[pk_a] <= pk_d;
      else if (ram_we) ram[ram_addr] <= ram_dout;
      ram_din <= ram[ram_addr];
   end

   // Bus monitor.
   always @(negedge clk) begin
      cyc++;
      if (if_done) n_if_done++;
      if (mem_done) begin n_mem_done++; last_mem_done_cyc = cyc; end
      if (if_done && mem_done) n_both++;
      if (ram_we) begin
         we_addr_q.push_back(ram_addr);
         we_data_q.push_back(ram_dout);
         last_we_cyc = cyc;
      end
   end

   task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
      @(negedge clk);
      pk_en = 1'b1; pk_a = a; pk_d = d;
      @(posedge clk);
      #1 pk_en = 1'b0;
   endtask

   task automatic wait_for(input bit is_if, input int max_cyc, output int l);
      l = -1;
      for (int c = 1; c <= max_cyc; c++) begin
         @(negedge clk);
         if (is_if ? if_done : mem_done) begin
            l = c;
            return;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; flush = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
      mem_len = 2'b00; if_addr = 32'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
      repeat (3) @(negedge clk);
      n_checks += 7;
      if (if_done !== 1'b0)     begin n_fail++; $display("FAIL reset_if_done got %0b want 0", if_done); end
      if (mem_done !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_done got %0b want 0", mem_done); end
      if (ram_we !== 1'b0)      begin n_fail++; $display("FAIL reset_ram_we got %0b want 0", ram_we); end
      if (ram_addr !== '0)      begin n_fail++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
      if (ram_dout !== 8'd0)    begin n_fail++; $display("FAIL reset_ram_dout got %h want 0", ram_dout); end
      if (if_inst !== 32'd0)    begin n_fail++; $display("FAIL reset_if_inst got %h want 0", if_inst); end
      if (mem_rdata !== 32'd0)  begin n_fail++; $display("FAIL reset_mem_rdata got %h want 0", mem_rdata); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_if_fetch();
      poke(17'h100, 8'h13); poke(17'h101, 8'h05); poke(17'h102, 8'h10); poke(17'h103, 8'h00);
      we_addr_q.delete(); we_data_q.delete();
      base = n_if_done;
      @(negedge clk);
      if_exp_q.push_back(32'h00100513);
      if_addr = 32'h100; if_req = 1'b1;
      wait_for(1'b1, 20, lat);
      exp = if_exp_q.pop_front();
      n_checks += 2;
      if (lat !== 6)       begin n_fail++; $display("FAIL fetch_latency got %0d want 6", lat); end
      if (if_inst !== exp) begin n_fail++; $display("FAIL fetch_data got %h want %h", if_inst, exp); end
      if_req = 1'b0;
      repeat (4) @(negedge clk);
      n_checks += 2;
      if (n_if_done - base !== 1)  begin n_fail++; $display("FAIL fetch_done_count got %0d want 1", n_if_done - base); end
      if (we_addr_q.size() !== 0)  begin n_fail++; $display("FAIL fetch_ram_we got %0d writes want 0", we_addr_q.size()); end
   endtask

   task automatic test_priority();
      poke(17'h2000, 8'h78); poke(17'h2001, 8'h56); poke(17'h2002, 8'h34); poke(17'h2003, 8'h12);
      @(negedge clk);
      mem_exp_q.push_back(32'h12345678);
      if_exp_q.push_back(32'h00100513);
      mem_we = 1'b0; mem_len = 2'b10; mem_addr = 32'h2000; mem_req = 1'b1;
      if_addr = 32'h100; if_req = 1'b1;
      wait_for(1'b0, 20, lat);
      exp = mem_exp_q.pop_front();
      n_checks += 3;
      if (lat !== 6)         begin n_fail++; $display("FAIL prio_mem_latency got %0d want 6", lat); end
      if (mem_rdata !== exp) begin n_fail++; $display("FAIL prio_mem_data got %h want %h", mem_rdata, exp); end
      if (if_done !== 1'b0)  begin n_fail++; $display("FAIL prio_if_early got %0b want 0", if_done); end
      mem_req = 1'b0;
      wait_for(1'b1, 20, lat);
      exp = if_exp_q.pop_front();
      n_checks += 2;
      if (lat !== 7)       begin n_fail++; $display("FAIL prio_if_latency got %0d want 7", lat); end
      if (if_inst !== exp) begin n_fail++; $display("FAIL prio_if_data got %h want %h", if_inst, exp); end
      if_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_store();
      logic [31:0] w;
      poke(17'h3002, 8'h55);
      @(negedge clk);
      we_addr_q.delete(); we_data_q.delete();
      mem_we = 1'b1; mem_len = 2'b00; mem_addr = 32'h3003; mem_wdata = 32'h123456A5; mem_req = 1'b1;
      wait_for(1'b0, 10, lat);
      mem_req = 1'b0;
      repeat (2) @(negedge clk);
      n_checks += 4;
      if (lat !== 2)              begin n_fail++; $display("FAIL sb_latency got %0d want 2", lat); end
      if (we_addr_q.size() !== 1) begin n_fail++; $display("FAIL sb_we_cycles got %0d want 1", we_addr_q.size()); end
      else if (we_addr_q[0] !== 17'h3003 || we_data_q[0] !== 8'hA5)
         begin n_fail++; $display("FAIL sb_bus got %h/%h want 03003/a5", we_addr_q[0], we_data_q[0]); end
      if (ram[17'h3002] !== 8'h55) begin n_fail++; $display("FAIL sb_neighbour got %h want 55", ram[17'h3002]); end

      we_addr_q.delete(); we_data_q.delete();
      w = 32'hDEADBEEF;
      mem_len = 2'b10; mem_addr = 32'h3000; mem_wdata = w; mem_req = 1'b1;
      wait_for(1'b0, 10, lat);
      mem_req = 1'b0;
      repeat (2) @(negedge clk);
      n_checks += 3;
      if (lat !== 5)              begin n_fail++; $display("FAIL sw_latency got %0d want 5", lat); end
      if (we_addr_q.size() !== 4) begin n_fail++; $display("FAIL sw_we_cycles got %0d want 4", we_addr_q.size()); end
      if (last_mem_done_cyc - last_we_cyc !== 1)
         begin n_fail++; $display("FAIL sw_done_after_write got %0d want 1", last_mem_done_cyc - last_we_cyc); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (ram[17'h3000 + i] !== w[8*i +: 8])
            begin n_fail++; $display("FAIL sw_byte%0d got %h want %h", i, ram[17'h3000 + i], w[8*i +: 8]); end
      end
   endtask

   task automatic test_wrap();
      poke(17'h1FFFF, 8'h34); poke(17'h00000, 8'h92);
      @(negedge clk);
      mem_exp_q.push_back(32'h00009234);
      mem_we = 1'b0; mem_len = 2'b01; mem_addr = 32'hABC1FFFF; mem_req = 1'b1;
      wait_for(1'b0, 10, lat);
      exp = mem_exp_q.pop_front();
      n_checks += 3;
      if (lat !== 4)           begin n_fail++; $display("FAIL wrap_latency got %0d want 4", lat); end
      if (mem_rdata !== exp)   begin n_fail++; $display("FAIL wrap_data got %h want %h", mem_rdata, exp); end
      if (ram_addr !== 17'h0)  begin n_fail++; $display("FAIL wrap_addr got %h want 00000", ram_addr); end
      mem_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_flush();
      poke(17'h200, 8'h93); poke(17'h201, 8'h00); poke(17'h202, 8'h10); poke(17'h203, 8'h00);
      @(negedge clk);
      base = n_if_done;
      if_addr = 32'h100; if_req = 1'b1;
      repeat (3) @(negedge clk);
      flush = 1'b1; if_req = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      repeat (10) @(negedge clk);
      n_checks += 2;
      if (n_if_done !== base)        begin n_fail++; $display("FAIL flush_no_done got %0d want 0", n_if_done - base); end
      if (if_inst !== 32'h00100513)  begin n_fail++; $display("FAIL flush_inst_held got %h want 00100513", if_inst); end
      if_exp_q.push_back(32'h00100093);
      if_addr = 32'h200; if_req = 1'b1;
      wait_for(1'b1, 20, lat);
      exp = if_exp_q.pop_front();
      n_checks += 2;
      if (lat !== 6)       begin n_fail++; $display("FAIL post_flush_latency got %0d want 6", lat); end
      if (if_inst !== exp) begin n_fail++; $display("FAIL post_flush_data got %h want %h", if_inst, exp); end
      if_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [7:0] want [4];
      for (int i = 0; i < 4; i++) poke(17'h4000 + 17'(i), 8'hFF);
      want[0] = 8'h44; want[1] = 8'h33; want[2] = 8'hFF; want[3] = 8'hFF;
      @(negedge clk);
      base = n_mem_done;
      we_addr_q.delete(); we_data_q.delete();
      mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h4000; mem_wdata = 32'h11223344; mem_req = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks += 7;
      if (ram_we !== 1'b0)     begin n_fail++; $display("FAIL rstmid_ram_we got %0b want 0", ram_we); end
      if (ram_addr !== '0)     begin n_fail++; $display("FAIL rstmid_ram_addr got %h want 0", ram_addr); end
      if (ram_dout !== 8'd0)   begin n_fail++; $display("FAIL rstmid_ram_dout got %h want 0", ram_dout); end
      if (mem_done !== 1'b0)   begin n_fail++; $display("FAIL rstmid_mem_done got %0b want 0", mem_done); end
      if (if_done !== 1'b0)    begin n_fail++; $display("FAIL rstmid_if_done got %0b want 0", if_done); end
      if (if_inst !== 32'd0)   begin n_fail++; $display("FAIL rstmid_if_inst got %h want 0", if_inst); end
      if (mem_rdata !== 32'd0) begin n_fail++; $display("FAIL rstmid_mem_rdata got %h want 0", mem_rdata); end
      mem_req = 1'b0; rst = 1'b1;
      repeat (5) @(negedge clk);
      n_checks += 2;
      if (n_mem_done !== base)    begin n_fail++; $display("FAIL rstmid_no_done got %0d want 0", n_mem_done - base); end
      if (we_addr_q.size() !== 2) begin n_fail++; $display("FAIL rstmid_we_cycles got %0d want 2", we_addr_q.size()); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (ram[17'h4000 + i] !== want[i])
            begin n_fail++; $display("FAIL rstmid_byte%0d got %h want %h", i, ram[17'h4000 + i], want[i]); end
      end
      mem_exp_q.push_back(32'h00000033);
      mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h4001; mem_req = 1'b1;
      wait_for(1'b0, 10, lat);
      exp = mem_exp_q.pop_front();
      n_checks += 2;
      if (lat !== 3)         begin n_fail++; $display("FAIL rstmid_after_latency got %0d want 3", lat); end
      if (mem_rdata !== exp) begin n_fail++; $display("FAIL rstmid_after_data got %h want %h", mem_rdata, exp); end
      mem_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_req_drop();
      poke(17'h5000, 8'h7E);
      @(negedge clk);
      mem_exp_q.push_back(32'h0000007E);
      mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h5000; mem_req = 1'b1;
      @(negedge clk);
      mem_req = 1'b0;
      wait_for(1'b0, 10, lat);
      exp = mem_exp_q.pop_front();
      n_checks += 2;
      if (lat !== 2)         begin n_fail++; $display("FAIL drop_latency got %0d want 2", lat); end
      if (mem_rdata !== exp) begin n_fail++; $display("FAIL drop_data got %h want %h", mem_rdata, exp); end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_if_fetch();
      test_priority();
      test_store();
      test_wrap();
      test_flush();
      test_reset_mid();
      test_req_drop();
      n_checks++;
      if (n_both !== 0) begin n_fail++; $display("FAIL both_done got %0d cycles want 0", n_both); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory controller sharing one byte-wide synchronous RAM between two requesters: the IF stage (instruction fetch) and the MEM stage (load/store).
- Serialises multi-byte accesses into byte transfers and assembles or splits 32-bit words little-endian.
- Signals completion with one-cycle done pulses. Requesters hold their stall requests to the stall bus until done.

Parameters:
ADDR_W, 17, width of RAM byte address; request addresses truncated to ADDR_W bits, byte increments wrap modulo 2^ADDR_W

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-low reset
flush  input  1  branch mispredict from EX; aborts in-flight or pending IF access
if_req  input  1  IF fetch request, held until if_done
if_addr  input  32  fetch byte address
if_done  output  1  one-cycle pulse, if_inst valid this cycle
if_inst  output  32  fetched instruction
mem_req  input  1  MEM access request, held until mem_done
mem_we  input  1  1=store, 0=load
mem_len  input  2  00=1 byte, 01=2 bytes, 10/11=4 bytes
mem_addr  input  32  access byte address
mem_wdata  input  32  store data; low N bytes used
mem_done  output  1  one-cycle pulse; mem_rdata valid this cycle for loads
mem_rdata  output  32  load data, zero-extended (MEM stage sign-extends)
ram_addr  output  ADDR_W  RAM byte address
ram_we  output  1  RAM write enable
ram_dout  output  8  RAM write data
ram_din  input  8  RAM read data; 1-cycle latency (addr driven in cycle t → data in cycle t+1)

Behaviour:
- All outputs registered. States: IDLE, IF_RD, MEM_RD, MEM_WR. 3-bit byte counter cnt.
- Reset (rst==0 at edge): state=IDLE, cnt=0. if_done, mem_done, ram_we, ram_addr, ram_dout, if_inst, mem_rdata all 0.
- Reset mid-operation aborts immediately, including stores. A partial store is left in RAM. No done pulse is issued.
- IDLE accepts a request only when if_done and mem_done are both low (the done cycle is never an accept cycle, because req is still high then).
- Priority: mem_req beats if_req. The IF request waits.
- IF is not accepted in a cycle where flush=1.
- Accept edge E0: latch address, length and wdata. Drive byte 0 (ram_addr = addr[ADDR_W-1:0]; for stores also ram_we=1 and ram_dout=byte0).
- Byte i is driven in the cycle after E(i). Address is addr+i, wrapping modulo 2^ADDR_W.
- Read of N bytes:
  - Byte i is captured from ram_din at edge E(i+2) into data[8i+7:8i].
  - Done is registered at E(N+1) and high for the cycle after E(N+1). 4-byte fetch: done visible 6 cycles after the request is first seen.
  - Unread upper bytes are 0.
  - ram_we is 0 throughout.
- Write of N bytes:
  - ram_we=1 for exactly N consecutive cycles (after E0..E(N-1)).
  - mem_done is registered at E(N) and ram_we drops at the same edge.
- After done, the state returns to IDLE, ram_we=0, and ram_addr holds its last value.
- if_inst/mem_rdata hold their value until the next completion of the same port.
- Flush:
  - In IF_RD: at the next edge, go to IDLE with no if_done. Captured bytes are discarded.
  - Never affects MEM_RD/MEM_WR, which belong to older instructions.
  - Flush during a MEM access leaves a waiting if_req unserved until flush is low.
- Requester dropping req mid-access: ignored. The access completes and done still pulses.
- if_done and mem_done are never high in the same cycle.

Test Plan:
- Reset, RAM[0x100..0x103]=13,05,10,00; if_req addr 0x100 → exactly one if_done pulse 6 cycles after request, if_inst=0x00100513, ram_we never 1.
- if_req and mem_req (LW, 0x2000, RAM=78,56,34,12) raised in the same cycle → mem_done with mem_rdata=0x12345678 first. IF accepted the cycle after mem_done, then if_done.
- SB addr 0x3003 wdata 0x123456A5 → one ram_we cycle, ram_addr=0x3003, ram_dout=0xA5. SW 0xDEADBEEF at 0x3000 → EF,BE,AD,DE at 0x3000..0x3003, mem_done one edge after the last write.
- LH addr 0x1FFFF (ADDR_W=17), RAM[0x1FFFF]=0x34, RAM[0x0]=0x92 → reads wrap to 0x00000, mem_rdata=0x00009234.
- flush pulse 3 cycles into an IF fetch → no if_done, IDLE next cycle. A new if_req at 0x200 after flush drops is served normally.
- rst low after 2 bytes of SW → next cycle ram_we=0, all outputs 0, no mem_done. Only 2 RAM bytes modified. A request after release is served from IDLE.
